uart_rx_frame: RTL and testbench

UART receive framer sitting directly downstream of the RX input synchronizer/glitch filter. It consumes the filtered serial line, the filter's falling-edge strobe and the shared 16x oversampling tick. It validates the start bit, samples data (LSB first), optional parity and one stop bit at bit centres, and presents each received word on a single-entry valid/ready output with error flags.

---
 rtl/uart_rx_frame.sv | 139 +++++++++++++
 tb/tb_uart_rx_frame.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART receive framer: validates the start bit, samples data/parity/stop at bit centres
// on the 16x tick, and holds each word in a single-entry valid/ready register with error flags.
module uart_rx_frame #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_16x,
  input  logic                 rx_filtered,
  input  logic                 falling_edge,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  // state    | meaning
  // S_IDLE   | line idle, waiting for a falling edge
  // S_START  | counting to mid start bit, then validate it
  // S_DATA   | sampling data bits LSB first at bit centres
  // S_PARITY | sampling the parity bit
  // S_STOP   | sampling the stop bit and completing the frame
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int               IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_t               state;
  logic [3:0]           cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;
  logic                 par_bad;
  logic                 complete;

  assign complete = (state == S_STOP) && tick_16x && (cnt == 4'd15);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;

      case (state)
        S_IDLE: begin
          if (falling_edge) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (tick_16x) begin
            if (cnt == 4'd7) begin
              cnt <= '0;
              if (!rx_filtered) begin
                state   <= S_DATA;
                bit_idx <= '0;
                par_acc <= 1'b0;
                par_bad <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick_16x) begin
            if (cnt == 4'd15) begin
              cnt     <= '0;
              shreg   <= {rx_filtered, shreg[DATA_BITS-1:1]};
              par_acc <= par_acc ^ rx_filtered;
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == LAST_IDX) begin
                state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (tick_16x) begin
            if (cnt == 4'd15) begin
              cnt     <= '0;
              state   <= S_STOP;
              par_bad <= (PARITY_MODE == 2) ? ~(par_acc ^ rx_filtered)
                                            :  (par_acc ^ rx_filtered);
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        S_STOP: begin
          if (tick_16x) begin
            if (cnt == 4'd15) begin
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // A completing frame may reuse the slot if the held word is consumed this cycle.
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          frame_err  <= ~rx_filtered;
          parity_err <= par_bad;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three instances (no/even/odd parity) driven from per-instance
// lines, checked every cycle against a tick-timed behavioural model plus literal expectations.
module tb_uart_rx_frame;
  localparam int NB       = 8;
  localparam int NI       = 3;
  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_16x = 1'b0;
  logic rx_line [NI];
  logic fe [NI];
  logic ready_force = 1'b1;
  logic rand_ready = 1'b0;
  logic rand_bit = 1'b1;
  wire  rx_ready = rand_ready ? rand_bit : ready_force;

  logic [NB-1:0] d_data [NI];
  logic d_valid [NI];
  logic d_ferr [NI];
  logic d_perr [NI];
  logic d_ovr [NI];
  logic d_busy [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_rx_frame #(.DATA_BITS(NB), .PARITY_MODE(g)) u_dut (
      .clk(clk), .rst(rst), .tick_16x(tick_16x),
      .rx_filtered(rx_line[g]), .falling_edge(fe[g]),
      .rx_data(d_data[g]), .rx_valid(d_valid[g]), .rx_ready(rx_ready),
      .frame_err(d_ferr[g]), .parity_err(d_perr[g]),
      .overrun(d_ovr[g]), .busy(d_busy[g]));
  end

  initial forever #5 clk = ~clk;

  int tick_div = 0;
  initial begin
    forever begin
      @(negedge clk);
      tick_div = (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
      tick_16x = (tick_div == 0);
      rand_bit = ($urandom_range(0, 3) != 0);
    end
  end

  // Behavioural model: count ticks since the edge; samples fall at 8 + 16*k.
  int            tick_total = 0;
  bit            m_act [NI];
  int            m_tk [NI];
  logic [NB-1:0] m_word [NI];
  logic          m_pbit [NI];
  logic [NB-1:0] e_data [NI];
  logic          e_valid [NI];
  logic          e_ferr [NI];
  logic          e_perr [NI];
  logic          e_ovr [NI];
  bit            m_done;
  logic          m_ferr, m_perr;
  int            m_k, m_plen;

  always @(posedge clk) begin
    if (tick_16x) tick_total++;
    for (int i = 0; i < NI; i++) begin
      e_ovr[i] = 1'b0;
      m_done = 1'b0;
      m_plen = (i == 0) ? 0 : 1;
      if (rst) begin
        m_act[i]   = 1'b0;
        e_data[i]  = '0;
        e_valid[i] = 1'b0;
        e_ferr[i]  = 1'b0;
        e_perr[i]  = 1'b0;
      end else begin
        if (!m_act[i]) begin
          if (fe[i]) begin
            m_act[i] = 1'b1;
            m_tk[i]  = 0;
          end
        end else if (tick_16x) begin
          m_tk[i]++;
          if (m_tk[i] >= 8 && (m_tk[i] - 8) % 16 == 0) begin
            m_k = (m_tk[i] - 8) / 16;
            if (m_k == 0) begin
              if (rx_line[i]) m_act[i] = 1'b0;
            end else if (m_k <= NB) begin
              m_word[i][m_k-1] = rx_line[i];
            end else if (m_k == NB + 1 && m_plen == 1) begin
              m_pbit[i] = rx_line[i];
            end
            if (m_k == NB + m_plen + 1) begin
              m_done   = 1'b1;
              m_act[i] = 1'b0;
              m_ferr   = !rx_line[i];
              if (i == 0)      m_perr = 1'b0;
              else if (i == 1) m_perr = ^{m_word[i], m_pbit[i]};
              else             m_perr = !(^{m_word[i], m_pbit[i]});
            end
          end
        end
        if (m_done) begin
          if (!e_valid[i] || rx_ready) begin
            e_data[i]  = m_word[i];
            e_ferr[i]  = m_ferr;
            e_perr[i]  = m_perr;
            e_valid[i] = 1'b1;
          end else begin
            e_ovr[i] = 1'b1;
          end
        end else if (e_valid[i] && rx_ready) begin
          e_valid[i] = 1'b0;
        end
      end
    end
  end

  int            checks = 0;
  int            errors = 0;
  logic          prev_v [NI];
  int            rise_cnt [NI];
  int            rise_tick [NI];
  int            edge_tick [NI];
  int            ovr_cnt [NI];
  logic [NB-1:0] last_word [NI];
  logic          last_ferr [NI];
  logic          last_perr [NI];
  int            r_idx;
  int            pre_rise, pre_ovr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    while (seen < n) begin
      @(posedge clk);
      if (tick_16x) seen++;
    end
  endtask

  task automatic send_frame(input int idx, input logic [7:0] d, input logic pbit,
                            input logic sbit, input int nbits_limit);
    logic bits [$];
    bits.push_back(1'b0);
    for (int b = 0; b < NB; b++) bits.push_back(d[b]);
    if (idx != 0) bits.push_back(pbit);
    bits.push_back(sbit);
    @(negedge clk);
    rx_line[idx] = 1'b0;
    fe[idx] = 1'b1;
    @(posedge clk);
    #1 edge_tick[idx] = tick_total;
    @(negedge clk);
    fe[idx] = 1'b0;
    for (int b = 0; b < bits.size() && b < nbits_limit; b++) begin
      if (b > 0) begin
        @(negedge clk);
        rx_line[idx] = bits[b];
      end
      wait_ticks(16);
    end
    @(negedge clk);
    rx_line[idx] = 1'b1;
  endtask

  task automatic send_false(input int idx);
    @(negedge clk);
    rx_line[idx] = 1'b0;
    fe[idx] = 1'b1;
    @(negedge clk);
    fe[idx] = 1'b0;
    wait_ticks(4);
    #1 chk("false_start_busy_mid", 32'(d_busy[idx]), 32'd1);
    @(negedge clk);
    rx_line[idx] = 1'b1;
    wait_ticks(4);
    #1 chk("false_start_busy_tick8", 32'(d_busy[idx]), 32'd0);
    wait_ticks(4);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rx_line[i] = 1'b1;
      fe[i] = 1'b0;
      prev_v[i] = 1'b0;
      rise_cnt[i] = 0;
      ovr_cnt[i] = 0;
    end
    fork
      forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
          checks++;
          if (d_data[i] !== e_data[i] || d_valid[i] !== e_valid[i] || d_ferr[i] !== e_ferr[i] ||
              d_perr[i] !== e_perr[i] || d_ovr[i] !== e_ovr[i] || d_busy[i] !== m_act[i]) begin
            errors++;
            $display("FAIL cycle_model dut%0d t=%0t got data=%h v=%b fe=%b pe=%b ovr=%b busy=%b expected data=%h v=%b fe=%b pe=%b ovr=%b busy=%b",
                     i, $time, d_data[i], d_valid[i], d_ferr[i], d_perr[i], d_ovr[i], d_busy[i],
                     e_data[i], e_valid[i], e_ferr[i], e_perr[i], e_ovr[i], m_act[i]);
          end
          if (d_valid[i] === 1'b1 && prev_v[i] !== 1'b1) begin
            rise_cnt[i]++;
            rise_tick[i] = tick_total;
            last_word[i] = d_data[i];
            last_ferr[i] = d_ferr[i];
            last_perr[i] = d_perr[i];
          end
          if (d_ovr[i] === 1'b1) ovr_cnt[i]++;
          prev_v[i] = d_valid[i];
        end
      end
    join_none

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("reset_data", 32'(d_data[i]), 32'd0);
      chk("reset_valid", 32'(d_valid[i]), 32'd0);
      chk("reset_flags", {29'd0, d_ferr[i], d_perr[i], d_ovr[i]}, 32'd0);
      chk("reset_busy", 32'(d_busy[i]), 32'd0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1, 0x55, ready high
    pre_rise = rise_cnt[0];
    send_frame(0, 8'h55, 1'b0, 1'b1, 99);
    chk("8n1_rise_count", 32'(rise_cnt[0] - pre_rise), 32'd1);
    chk("8n1_latency_ticks", 32'(rise_tick[0] - edge_tick[0]), 32'd152);
    chk("8n1_data", 32'(last_word[0]), 32'h55);
    chk("8n1_flags", {30'd0, last_ferr[0], last_perr[0]}, 32'd0);
    chk("8n1_valid_consumed", 32'(d_valid[0]), 32'd0);

    // false start followed by a good frame
    pre_rise = rise_cnt[0];
    send_false(0);
    chk("false_start_no_valid", 32'(rise_cnt[0] - pre_rise), 32'd0);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 99);
    chk("after_false_rise", 32'(rise_cnt[0] - pre_rise), 32'd1);
    chk("after_false_data", 32'(last_word[0]), 32'h3C);

    // frame error
    send_frame(0, 8'hA3, 1'b0, 1'b0, 99);
    chk("ferr_data", 32'(last_word[0]), 32'hA3);
    chk("ferr_flag", 32'(last_ferr[0]), 32'd1);
    repeat (4) @(negedge clk);

    // parity
    send_frame(1, 8'h07, 1'b0, 1'b1, 99);
    chk("even_bad_latency", 32'(rise_tick[1] - edge_tick[1]), 32'd168);
    chk("even_bad_data", 32'(last_word[1]), 32'h07);
    chk("even_bad_perr", 32'(last_perr[1]), 32'd1);
    send_frame(1, 8'h07, 1'b1, 1'b1, 99);
    chk("even_ok_perr", 32'(last_perr[1]), 32'd0);
    send_frame(2, 8'h07, 1'b0, 1'b1, 99);
    chk("odd_ok_perr", 32'(last_perr[2]), 32'd0);
    chk("odd_ok_ferr", 32'(last_ferr[2]), 32'd0);

    // overrun
    ready_force = 1'b0;
    pre_ovr = ovr_cnt[0];
    send_frame(0, 8'h11, 1'b0, 1'b1, 99);
    send_frame(0, 8'h22, 1'b0, 1'b1, 99);
    chk("overrun_pulses", 32'(ovr_cnt[0] - pre_ovr), 32'd1);
    chk("overrun_held_data", 32'(d_data[0]), 32'h11);
    chk("overrun_valid_held", 32'(d_valid[0]), 32'd1);
    @(negedge clk);
    ready_force = 1'b1;
    @(posedge clk);
    #1 chk("consume_valid_drop", 32'(d_valid[0]), 32'd0);

    // reset mid-DATA after three data bits
    send_frame(0, 8'hF0, 1'b0, 1'b1, 4);
    rst = 1'b1;
    #1;
    chk("midreset_data", 32'(d_data[0]), 32'd0);
    chk("midreset_valid_busy", {30'd0, d_valid[0], d_busy[0]}, 32'd0);
    chk("midreset_flags", {29'd0, d_ferr[0], d_perr[0], d_ovr[0]}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    pre_rise = rise_cnt[0];
    send_frame(0, 8'hF0, 1'b0, 1'b1, 99);
    chk("post_reset_rise", 32'(rise_cnt[0] - pre_rise), 32'd1);
    chk("post_reset_data", 32'(last_word[0]), 32'hF0);
    chk("post_reset_flags", {30'd0, last_ferr[0], last_perr[0]}, 32'd0);

    // randomized traffic with random consumer back-pressure
    rand_ready = 1'b1;
    repeat (40) begin
      r_idx = $urandom_range(0, NI - 1);
      if ($urandom_range(0, 7) == 0) send_false(r_idx);
      else send_frame(r_idx, 8'($urandom), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) != 0), 99);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    rand_ready = 1'b0;
    ready_force = 1'b1;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
